ethernet_mdio_status_poll: RTL

ETHERNET_MDIO_STATUS_POLL -- requirements
Module: ethernet_mdio_status_poll

---
 rtl/eth_mdio_pkg.sv | 35 +++
 rtl/ethernet_mdio_poll_timer.sv | 25 ++
 rtl/ethernet_mdio_status_poll.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/eth_mdio_pkg.sv
// Shared MDIO definitions for the Ethernet PHY status poller: opcodes,
// register addresses, status bit positions, speed encoding and FSM states.
package eth_mdio_pkg;

  localparam logic [1:0] MDIO_OP_READ = 2'b10;

  localparam logic [4:0] REG_BMSR   = 5'h01;
  localparam logic [4:0] REG_PHYSTS = 5'h11;

  localparam int unsigned BMSR_LINK_BIT     = 2;
  localparam int unsigned PHYSTS_SPEED_HI   = 15;
  localparam int unsigned PHYSTS_SPEED_LO   = 14;
  localparam int unsigned PHYSTS_DUPLEX_BIT = 13;
  localparam int unsigned PHYSTS_LINK_BIT   = 10;

  localparam logic [23:0] SIM_POLL_CYCLES = 24'd1024;

  typedef enum logic [1:0] {
    SPEED_10M  = 2'b00,
    SPEED_100M = 2'b01,
    SPEED_1G   = 2'b10,
    SPEED_RSVD = 2'b11
  } speed_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BMSR_CMD,
    ST_BMSR_DATA,
    ST_STS_CMD,
    ST_STS_DATA,
    ST_UPDATE
  } poll_state_e;

endpackage

// File: rtl/ethernet_mdio_poll_timer.sv
// 24-bit poll interval counter: loadable, decrements and saturates at zero.
module ethernet_mdio_poll_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] load_value,
  input  logic        dec,
  output logic        zero
);

  logic [23:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 24'd1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ethernet_mdio_status_poll.sv
// Periodically reads PHY BMSR and PHYSTS over an MDIO command interface and
// publishes link/speed/duplex. Define MDIO_POLL_TIMEOUT_EN for response timeout.
module ethernet_mdio_status_poll
  import eth_mdio_pkg::*;
#(
  parameter bit          SIMULATION  = 1'b0,
  parameter logic [4:0]  PHY_ADDR    = 5'h03,
  parameter logic [23:0] POLL_CYCLES = 24'd12500000
) (
  input  logic        clk_eth_i,
  input  logic        rst_eth_i,
  input  logic        init_done_i,
  output logic [4:0]  cmd_phy_addr_o,
  output logic [4:0]  cmd_reg_addr_o,
  output logic [15:0] cmd_data_o,
  output logic [1:0]  cmd_opcode_o,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  input  logic [15:0] data_in_i,
  input  logic        data_in_valid_i,
  output logic        data_in_ready_o,
  output logic        link_up_o,
  output logic [1:0]  speed_o,
  output logic        duplex_o,
  output logic        status_valid_o,
  output logic        status_change_o,
  output logic        timeout_o
);

  localparam logic [23:0] INTERVAL = SIMULATION ? SIM_POLL_CYCLES : POLL_CYCLES;

  poll_state_e state;
  logic        link_bmsr;
  logic        sts_link;
  logic        sts_duplex;
  logic [1:0]  sts_speed;
  logic        timer_load;
  logic        timer_dec;
  logic        timer_zero;
  logic        to_hit;
  logic [3:0]  new_status;
  logic        unused_data;

  assign cmd_phy_addr_o  = PHY_ADDR;
  assign cmd_data_o      = '0;
  assign cmd_opcode_o    = MDIO_OP_READ;
  assign data_in_ready_o = 1'b1;
  assign unused_data     = ^{data_in_i[12:11], data_in_i[9:3], data_in_i[1:0]};

`ifdef MDIO_POLL_TIMEOUT_EN
  logic [15:0] to_cnt;

  always_ff @(posedge clk_eth_i) begin
    if (rst_eth_i || data_in_valid_i ||
        !((state == ST_BMSR_DATA) || (state == ST_STS_DATA))) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

  // Fires on the edge where the count would reach 16'hFFFF, i.e. 65535 cycles after acceptance.
  assign to_hit = ((state == ST_BMSR_DATA) || (state == ST_STS_DATA)) &&
                  !data_in_valid_i && (to_cnt == 16'hFFFE);
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    timer_load = ((state == ST_IDLE) && init_done_i) || (state == ST_UPDATE) || to_hit;
    timer_dec  = (state == ST_WAIT) && init_done_i;
    new_status = {link_bmsr & sts_link, sts_speed, sts_duplex};
  end

  ethernet_mdio_poll_timer u_timer (
    .clk        (clk_eth_i),
    .rst        (rst_eth_i),
    .load       (timer_load),
    .load_value (INTERVAL),
    .dec        (timer_dec),
    .zero       (timer_zero)
  );

  always_ff @(posedge clk_eth_i) begin
    if (rst_eth_i) begin
      state           <= ST_IDLE;
      cmd_valid_o     <= 1'b0;
      cmd_reg_addr_o  <= REG_BMSR;
      link_bmsr       <= 1'b0;
      sts_link        <= 1'b0;
      sts_duplex      <= 1'b0;
      sts_speed       <= '0;
      link_up_o       <= 1'b0;
      speed_o         <= '0;
      duplex_o        <= 1'b0;
      status_valid_o  <= 1'b0;
      status_change_o <= 1'b0;
      timeout_o       <= 1'b0;
    end else begin
      status_change_o <= 1'b0;
      timeout_o       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (init_done_i) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!init_done_i) begin
            state          <= ST_IDLE;
            status_valid_o <= 1'b0;
          end else if (timer_zero) begin
            state          <= ST_BMSR_CMD;
            cmd_valid_o    <= 1'b1;
            cmd_reg_addr_o <= REG_BMSR;
          end
        end
        ST_BMSR_CMD: begin
          if (cmd_ready_i) begin
            cmd_valid_o <= 1'b0;
            state       <= ST_BMSR_DATA;
          end
        end
        ST_BMSR_DATA: begin
          if (data_in_valid_i) begin
            link_bmsr      <= data_in_i[BMSR_LINK_BIT];
            state          <= ST_STS_CMD;
            cmd_valid_o    <= 1'b1;
            cmd_reg_addr_o <= REG_PHYSTS;
          end else if (to_hit) begin
            timeout_o      <= 1'b1;
            status_valid_o <= 1'b0;
            link_up_o      <= 1'b0;
            state          <= ST_WAIT;
          end
        end
        ST_STS_CMD: begin
          if (cmd_ready_i) begin
            cmd_valid_o <= 1'b0;
            state       <= ST_STS_DATA;
          end
        end
        ST_STS_DATA: begin
          if (data_in_valid_i) begin
            sts_speed  <= data_in_i[PHYSTS_SPEED_HI:PHYSTS_SPEED_LO];
            sts_duplex <= data_in_i[PHYSTS_DUPLEX_BIT];
            sts_link   <= data_in_i[PHYSTS_LINK_BIT];
            state      <= ST_UPDATE;
          end else if (to_hit) begin
            timeout_o      <= 1'b1;
            status_valid_o <= 1'b0;
            link_up_o      <= 1'b0;
            state          <= ST_WAIT;
          end
        end
        ST_UPDATE: begin
          link_up_o       <= new_status[3];
          speed_o         <= new_status[2:1];
          duplex_o        <= new_status[0];
          status_valid_o  <= 1'b1;
          status_change_o <= (new_status != {link_up_o, speed_o, duplex_o}) || !status_valid_o;
          state           <= ST_WAIT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
